store_rmw_sequencer: RTL and testbench

Multicycle store sequencer sitting between the datapath's B register and memory. For word stores it writes B directly; for halfword and byte stores it performs a read-modify-write:
- read the addressed word into an internal MDR;
- merge the low bits of B into it;
- write the merged word back.

It owns the memory write strobe during stores and reports completion to the main control FSM with a one-cycle `done` pulse.

---
 rtl/store_rmw_sequencer_pkg.sv | 20 ++
 rtl/store_rmw_sequencer_merge.sv | 23 ++
 rtl/store_rmw_sequencer.sv | 93 +++++++++
 tb/tb_store_rmw_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_sequencer_pkg.sv
// Shared state encoding and store-size codes for the store read-modify-write sequencer.
package store_rmw_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SS_W = 2'b00;
    localparam logic [1:0] SS_H = 2'b01;

    // Byte stores are any code with bit 1 set (10 and 11 alike).
    function automatic logic is_sb(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/store_rmw_sequencer_merge.sv
// Word-aligned store merge: sw passes B through, sh/sb replace only the low lane(s) of the MDR word.
// Purely combinational; address low bits never steer lane selection.
module store_merge
    import store_rmw_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] b_q,
    input  logic [DATA_W-1:0] mdr_q,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        mem_wdata = b_q;
        if (is_sb(op)) begin
            mem_wdata = {mdr_q[DATA_W-1:8], b_q[7:0]};
        end else if (op == SS_H) begin
            mem_wdata = {mdr_q[DATA_W-1:16], b_q[15:0]};
        end
    end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Multicycle store sequencer: direct write for sw, read-merge-write for sh/sb, one-cycle done pulse.
// Outputs other than mem_wdata are registered; mem_wdata is combinational from captured registers only.
module store_rmw_sequencer
    import store_rmw_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        ss_op,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;

    assign mem_addr = addr_q;

    store_merge #(.DATA_W(DATA_W)) u_merge (
        .op        (op_q),
        .b_q       (b_q),
        .mdr_q     (mdr_q),
        .mem_wdata (mem_wdata)
    );

    // Strobes are set on the transition into their state so they are pure flop outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            b_q    <= '0;
            op_q   <= SS_W;
            mdr_q  <= '0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_q <= addr;
                        b_q    <= b_data;
                        op_q   <= ss_op;
                        busy   <= 1'b1;
                        if (ss_op == SS_W) begin
                            state  <= ST_WRITE;
                            mem_wr <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    mdr_q  <= mem_rdata;
                    mem_wr <= 1'b1;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Randomised and directed bench for store_rmw_sequencer with a word memory and a lane-merge reference model.
module tb_store_rmw_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ss_op = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] b_data = '0;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mdr_q;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] exp_mdr;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    always #5 clk = ~clk;

    store_rmw_sequencer #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ss_op     (ss_op),
        .addr      (addr),
        .b_data    (b_data),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mdr_q     (mdr_q),
        .busy      (busy),
        .done      (done)
    );

    // Word memory with one-cycle registered read; the bench preloads it through pl_*.
    always @(posedge clk) begin
        if (pl_en)       mem[pl_idx] <= pl_dat;
        else if (mem_wr) mem[mem_addr[6:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[6:2]];
    end

    function automatic logic [31:0] model_merge(input logic [1:0] op, input logic [31:0] old_w,
                                                input logic [31:0] b);
        if (op[1])          return (old_w & 32'hFFFF_FF00) | (b & 32'h0000_00FF);
        else if (op[0])     return (old_w & 32'hFFFF_0000) | (b & 32'h0000_FFFF);
        else                return b;
    endfunction

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_dat = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One store launched at the next edge; mask[c] is the start level driven during cycle c.
    task automatic run_store(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [15:0] mask, input bit scramble);
        int w_cyc, n_wr, n_done;
        logic [4:0]  idx;
        logic [31:0] exp_w;
        idx   = a[6:2];
        w_cyc = (op == 2'b00) ? 1 : 3;
        if (op != 2'b00) exp_mdr = ref_mem[idx];
        exp_w = model_merge(op, ref_mem[idx], b);
        n_wr = 0; n_done = 0;
        @(negedge clk);
        start = 1'b1; ss_op = op; addr = a; b_data = b;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_wr   += int'(mem_wr);
            n_done += int'(done);
            checks++;
            if (busy !== (c <= w_cyc)) begin
                errors++; $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, c <= w_cyc);
            end
            checks++;
            if (mem_wr !== (c == w_cyc)) begin
                errors++; $display("FAIL %s mem_wr cycle %0d: got %b want %b", name, c, mem_wr, c == w_cyc);
            end
            checks++;
            if (done !== (c == w_cyc + 1)) begin
                errors++; $display("FAIL %s done cycle %0d: got %b want %b", name, c, done, c == w_cyc + 1);
            end
            if (c == w_cyc) begin
                checks++;
                if (mem_addr !== a || mem_wdata !== exp_w) begin
                    errors++;
                    $display("FAIL %s write: got addr %h data %h want addr %h data %h",
                             name, mem_addr, mem_wdata, a, exp_w);
                end
            end
            start = mask[c];
            if (scramble && c == 1) begin
                addr = $urandom; b_data = $urandom; ss_op = 2'($urandom);
            end
        end
        start = 1'b0;
        ref_mem[idx] = exp_w;
        checks++;
        if (n_wr != 1 || n_done != 1) begin
            errors++; $display("FAIL %s pulse count: got wr=%0d done=%0d want 1/1", name, n_wr, n_done);
        end
        checks++;
        if (mdr_q !== exp_mdr) begin
            errors++; $display("FAIL %s mdr_q: got %h want %h", name, mdr_q, exp_mdr);
        end
        checks++;
        if (mem[idx] !== ref_mem[idx]) begin
            errors++; $display("FAIL %s memory word: got %h want %h", name, mem[idx], ref_mem[idx]);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_addr, mem_wdata, mdr_q, mem_wr, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got addr %h wdata %h mdr %h wr %b busy %b done %b want all 0",
                     mem_addr, mem_wdata, mdr_q, mem_wr, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_mdr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_addr, mem_wdata, mdr_q, mem_wr, busy, done} !== '0) begin
                errors++; $display("FAIL idle outputs cycle %0d: got wr %b busy %b done %b wdata %h want 0",
                                   i, mem_wr, busy, done, mem_wdata);
            end
        end
    endtask

    task automatic test_directed;
        run_store("sw", 2'b00, 32'h40, 32'hDEAD_BEEF, 16'h0, 1'b0);
        preload(5'd16, 32'h1122_3344);
        run_store("sh", 2'b01, 32'h40, 32'hAAAA_BBBB, 16'h0, 1'b0);
        checks++;
        if (mem[16] !== 32'h1122_BBBB) begin
            errors++; $display("FAIL sh literal: got %h want 1122bbbb", mem[16]);
        end
        preload(5'd16, 32'h1122_3344);
        run_store("sb11", 2'b11, 32'h40, 32'h0000_00CC, 16'h0, 1'b0);
        checks++;
        if (mem[16] !== 32'h1122_33CC) begin
            errors++; $display("FAIL sb literal: got %h want 112233cc", mem[16]);
        end
    endtask

    task automatic test_start_ignored;
        preload(5'd3, 32'h5566_7788);
        run_store("start_ignored", 2'b01, 32'h0E, 32'h1234_ABCD, 16'b0000_0000_0000_1010, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] b1, b2;
        int wr_at [$];
        int n_done;
        b1 = $urandom; b2 = $urandom; n_done = 0;
        @(negedge clk);
        start = 1'b1; ss_op = 2'b00; addr = 32'h24; b_data = b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                wr_at.push_back(c);
                checks++;
                if (mem_wdata !== ((wr_at.size() == 1) ? b1 : b2)) begin
                    errors++; $display("FAIL b2b data cycle %0d: got %h want %h", c, mem_wdata,
                                       (wr_at.size() == 1) ? b1 : b2);
                end
            end
            n_done += int'(done);
            if (c == 1) b_data = b2;
            if (c == 4) start = 1'b0;
        end
        ref_mem[9] = b2;
        checks++;
        if (wr_at.size() != 2 || n_done != 2) begin
            errors++; $display("FAIL b2b counts: got wr=%0d done=%0d want 2/2", wr_at.size(), n_done);
        end else begin
            checks++;
            if (wr_at[0] != 1 || wr_at[1] != 4) begin
                errors++; $display("FAIL b2b spacing: got writes at %0d,%0d want 1,4", wr_at[0], wr_at[1]);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] keep;
        keep = $urandom;
        preload(5'd5, keep);
        @(negedge clk);
        start = 1'b1; ss_op = 2'b10; addr = 32'h14; b_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mdr_q !== '0) begin
            errors++; $display("FAIL reset mid: got wr %b busy %b done %b mdr %h want 0", mem_wr, busy, done, mdr_q);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            checks++;
            if (mem_wr !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL reset mid quiet %0d: got wr %b done %b want 0", i, mem_wr, done);
            end
        end
        exp_mdr = '0;
        checks++;
        if (mem[5] !== keep) begin
            errors++; $display("FAIL reset mid memory: got %h want %h", mem[5], keep);
        end
        run_store("sw_after_reset", 2'b00, 32'h18, $urandom, 16'h0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [4:0] idx;
            idx = 5'($urandom_range(0, 31));
            run_store("random", 2'($urandom), {25'd0, idx, 2'($urandom)}, $urandom, 16'h0, 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = '0;
        end
        exp_mdr = '0;
        test_reset;
        for (int i = 0; i < 32; i++) begin
            preload(5'(i), $urandom);
        end
        test_directed;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
